ofs_fim_pcie_dm_rd_channel_sched: RTL and testbench

Read-channel scheduler placed in front of the DM request splitter's TX-A/TX-B inputs. It grants DM read requests to only one TX channel at a time. It counts original reads in flight and retires them on each final-completion (FC) packet. Before ownership moves to the other channel, every outstanding read must complete. This keeps split completions from interleaving, which the completion merge logic needs.

---
 rtl/ofs_fim_pcie_dm_rd_channel_sched.sv | 147 ++++++++++++++
 tb/tb_ofs_fim_pcie_dm_rd_channel_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ofs_fim_pcie_dm_rd_channel_sched.sv
// Read-channel scheduler for the DM request splitter. Only one TX channel
// (A or B) may issue DM reads at a time. Before ownership can move to the
// other channel, every read in flight must retire on its final completion.
// This keeps split completions from the two channels from interleaving.
module ofs_fim_pcie_dm_rd_channel_sched #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int SWITCH_HOLD     = 16,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1),
  localparam int BRST_W = $clog2(SWITCH_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_rd_req,
  output logic [1:0]       o_rd_allow,
  input  logic [1:0]       i_rd_fire,
  input  logic             i_cpl_done,
  output logic [1:0]       o_owner,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [BRST_W:0]   HOLD_EXT = (BRST_W + 1)'(SWITCH_HOLD);
  localparam logic [BRST_W-1:0] BRST_MAX = BRST_W'(SWITCH_HOLD);

  state_t            state, state_nxt;
  logic              owner, owner_nxt;          // 0 = A, 1 = B
  logic              last_owner, last_owner_nxt;
  logic [CNT_W-1:0]  count;
  logic [BRST_W-1:0] burst;
  logic              burst_clr;
  logic              err;

  logic              own_req, oth_req, own_fire, fire_any;
  logic              burst_hit, err_set;
  logic [1:0]        rd_allow;

  assign own_req  = i_rd_req[owner];
  assign oth_req  = i_rd_req[~owner];
  assign own_fire = i_rd_fire[owner];
  assign fire_any = |i_rd_fire;

  // The hold limit also counts an owner fire in the current cycle. The switch
  // then lands right after the SWITCH_HOLD-th read, and that read stays legal.
  assign burst_hit = (({1'b0, burst} + {{BRST_W{1'b0}}, own_fire}) >= HOLD_EXT);

  // Grant depends only on registered state, owner and count
  always_comb begin
    rd_allow = '0;
    if (state == S_OWN && count < CNT_MAX) begin
      rd_allow = owner ? 2'b10 : 2'b01;
    end
  end

  // Next-state, owner hand-off and burst-clear decode
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_clr      = 1'b0;
    unique case (state)
      S_IDLE: begin
        burst_clr = 1'b1;
        if (i_rd_req != 2'b00) begin
          state_nxt = S_OWN;
          owner_nxt = (i_rd_req == 2'b11) ? ~last_owner : i_rd_req[1];
        end
      end
      S_OWN: begin
        if (oth_req && (burst_hit || !own_req)) begin
          state_nxt = S_DRAIN;
        end else if (count == '0 && !own_req && !oth_req) begin
          state_nxt      = S_IDLE;
          last_owner_nxt = owner;
        end
      end
      S_DRAIN: begin
        if (count == '0) begin
          state_nxt      = S_OWN;
          owner_nxt      = ~owner;
          last_owner_nxt = owner;
          burst_clr      = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and ownership registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Owner burst counter, saturating at the hold limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst <= '0;
    end else if (burst_clr) begin
      burst <= '0;
    end else if (state == S_OWN && own_fire && burst != BRST_MAX) begin
      burst <= burst + BRST_W'(1);
    end
  end

  // Reads in flight: +1 on a fire, -1 on a final completion, hold when both occur
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (fire_any && !i_cpl_done) begin
      if (count != CNT_MAX) count <= count + CNT_W'(1);
    end else if (!fire_any && i_cpl_done && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign err_set = (|(i_rd_fire & ~rd_allow)) || (&i_rd_fire) ||
                   (i_cpl_done && !fire_any && count == '0);

  // Sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  assign o_rd_allow    = rd_allow;
  assign o_owner       = (state == S_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign o_outstanding = count;
  assign o_err         = err;

endmodule

// File: tb/tb_ofs_fim_pcie_dm_rd_channel_sched.sv
// Scoreboard bench for the read-channel scheduler. Each directed vector sets
// the inputs for one cycle and queues the outputs expected during that cycle.
// A negedge monitor pops each entry and compares it with the selected DUT.
// u_main uses MAX_OUTSTANDING=8, SWITCH_HOLD=4.
// u_cap uses MAX_OUTSTANDING=2 to exercise the outstanding cap.
module tb_ofs_fim_pcie_dm_rd_channel_sched;

  typedef struct {
    int         id;
    bit         sel;
    logic [1:0] allow;
    logic [1:0] owner;
    int         cnt;
    logic       err;
  } exp_t;

  localparam bit M = 1'b0;
  localparam bit C = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0] req_m = '0, fire_m = '0, allow_m, owner_m;
  logic       done_m = 1'b0, err_m;
  logic [3:0] out_m;

  logic [1:0] req_c = '0, fire_c = '0, allow_c, owner_c;
  logic       done_c = 1'b0, err_c;
  logic [1:0] out_c;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vid    = 0;

  always #5 clk = ~clk;

  ofs_fim_pcie_dm_rd_channel_sched #(.MAX_OUTSTANDING(8), .SWITCH_HOLD(4)) u_main (
    .clk(clk), .rst(rst), .i_rd_req(req_m), .o_rd_allow(allow_m),
    .i_rd_fire(fire_m), .i_cpl_done(done_m), .o_owner(owner_m),
    .o_outstanding(out_m), .o_err(err_m)
  );

  ofs_fim_pcie_dm_rd_channel_sched #(.MAX_OUTSTANDING(2), .SWITCH_HOLD(16)) u_cap (
    .clk(clk), .rst(rst), .i_rd_req(req_c), .o_rd_allow(allow_c),
    .i_rd_fire(fire_c), .i_cpl_done(done_c), .o_owner(owner_c),
    .o_outstanding(out_c), .o_err(err_c)
  );

  // One cycle: drive inputs just after the edge, queue the outputs expected during this cycle
  task automatic vec(input bit sel, input logic r, input logic [1:0] req,
                     input logic [1:0] fire, input logic done,
                     input logic [1:0] ea, input logic [1:0] eo,
                     input int ec, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    if (sel == M) begin
      req_m = req; fire_m = fire; done_m = done;
      req_c = '0;  fire_c = '0;   done_c = 1'b0;
    end else begin
      req_c = req; fire_c = fire; done_c = done;
      req_m = '0;  fire_m = '0;   done_m = 1'b0;
    end
    e.id = vid; e.sel = sel; e.allow = ea; e.owner = eo; e.cnt = ec; e.err = ee;
    vid++;
    sb.push_back(e);
  endtask

  // Monitor: compare the selected DUT against the oldest queued expectation
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] a_allow, a_owner;
    int         a_cnt;
    logic       a_err;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == M) begin
        a_allow = allow_m; a_owner = owner_m; a_cnt = int'(out_m); a_err = err_m;
      end else begin
        a_allow = allow_c; a_owner = owner_c; a_cnt = int'(out_c); a_err = err_c;
      end
      n_vec++;
      if (a_allow !== e.allow || a_owner !== e.owner || a_cnt != e.cnt || a_err !== e.err) begin
        n_miss++;
        $display("FAIL vec%0d %s: got allow=%b owner=%b cnt=%0d err=%b, want allow=%b owner=%b cnt=%0d err=%b",
                 e.id, (e.sel == M) ? "main" : "cap", a_allow, a_owner, a_cnt, a_err,
                 e.allow, e.owner, e.cnt, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    vec(M, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    // Tie after reset goes to A, then A runs three reads and drains to idle
    vec(M, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 0, 0);
    vec(M, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 1, 0);
    vec(M, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 2, 0);
    vec(M, 0, 2'b00, 2'b00, 1, 2'b01, 2'b01, 3, 0);
    vec(M, 0, 2'b00, 2'b00, 1, 2'b01, 2'b01, 2, 0);
    vec(M, 0, 2'b00, 2'b00, 1, 2'b01, 2'b01, 1, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b01, 2'b01, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    // Second tie goes to B
    vec(M, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    // Forced switch: four A reads, drain, B granted two cycles after last FC
    vec(M, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 0, 2'b11, 2'b01, 0, 2'b01, 2'b01, 0, 0);
    vec(M, 0, 2'b11, 2'b01, 0, 2'b01, 2'b01, 1, 0);
    vec(M, 0, 2'b11, 2'b01, 0, 2'b01, 2'b01, 2, 0);
    vec(M, 0, 2'b11, 2'b01, 0, 2'b01, 2'b01, 3, 0);
    vec(M, 0, 2'b11, 2'b00, 0, 2'b00, 2'b01, 4, 0);
    vec(M, 0, 2'b11, 2'b00, 1, 2'b00, 2'b01, 4, 0);
    vec(M, 0, 2'b11, 2'b00, 1, 2'b00, 2'b01, 3, 0);
    vec(M, 0, 2'b11, 2'b00, 1, 2'b00, 2'b01, 2, 0);
    vec(M, 0, 2'b11, 2'b00, 1, 2'b00, 2'b01, 1, 0);
    vec(M, 0, 2'b11, 2'b00, 0, 2'b00, 2'b01, 0, 0);
    vec(M, 0, 2'b10, 2'b00, 0, 2'b10, 2'b10, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b10, 2'b10, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    // Completion underflow: err sets, count stays 0
    vec(M, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 1);
    // Reach DRAIN with three reads in flight, then async reset mid-cycle
    vec(M, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 0, 1);
    vec(M, 0, 2'b11, 2'b01, 0, 2'b01, 2'b01, 0, 1);
    vec(M, 0, 2'b11, 2'b01, 0, 2'b01, 2'b01, 1, 1);
    vec(M, 0, 2'b10, 2'b01, 0, 2'b01, 2'b01, 2, 1);
    vec(M, 0, 2'b10, 2'b00, 0, 2'b00, 2'b01, 3, 1);
    vec(M, 1, 2'b10, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b01, 2'b01, 0, 0);
    // Fire on B without a grant: sticky err
    vec(M, 0, 2'b00, 2'b10, 0, 2'b00, 2'b00, 0, 0);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 1);
    vec(M, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1, 1);
    // Outstanding cap on the MAX_OUTSTANDING=2 instance
    vec(C, 0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0, 0);
    vec(C, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 0, 0);
    vec(C, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 1, 0);
    vec(C, 0, 2'b01, 2'b00, 0, 2'b00, 2'b01, 2, 0);
    vec(C, 0, 2'b01, 2'b00, 1, 2'b00, 2'b01, 2, 0);
    vec(C, 0, 2'b01, 2'b01, 1, 2'b01, 2'b01, 1, 0);
    vec(C, 0, 2'b01, 2'b01, 0, 2'b01, 2'b01, 1, 0);
    vec(C, 0, 2'b01, 2'b00, 0, 2'b00, 2'b01, 2, 0);
    // Both fire bits at once: err sets, count saturated at the cap
    vec(C, 0, 2'b01, 2'b11, 0, 2'b00, 2'b01, 2, 0);
    vec(C, 0, 2'b00, 2'b00, 0, 2'b00, 2'b01, 2, 1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
